// File: rtl/pico_periph_bridge.sv
// picorv32 native memory port to the w_REQ/r_REQ peripheral bus.
// Word-only peripherals: partial-strobe writes are done as read-modify-write.
//
// state    | meaning
// IDLE     | waiting for a valid, in-window request
// RD_WAIT  | read issued, counting down the peripheral read latency
// RMW_WAIT | read half of a read-modify-write, counting down the latency
// RMW_WR   | write strobe out (full word or merged), mem_ready raised next
// ACK      | mem_ready high for one cycle
module pico_periph_bridge #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = 32'hFFFF_F000,
  parameter int                    RD_LATENCY = 1
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  w_REQ,
  output logic                  r_REQ,
  output logic [ADDR_WIDTH-1:0] w_ADDR,
  output logic [ADDR_WIDTH-1:0] r_ADDR,
  output logic [DATA_WIDTH-1:0] w_DATA,
  input  logic [DATA_WIDTH-1:0] r_DATA
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RMW_WAIT,
    RMW_WR,
    ACK
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(RD_LATENCY);

  state_t                  state;
  logic [3:0]              count;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              wstrb_q;
  logic                    hit;
  logic [ADDR_WIDTH-1:0]   addr_aligned;
  logic [DATA_WIDTH-1:0]   merged;

  assign hit          = (mem_addr & ADDR_MASK) == BASE_ADDR;
  assign addr_aligned = {mem_addr[ADDR_WIDTH-1:2], 2'b00};

  // Strobed lanes come from the core, the rest from the word just read back.
  always_comb begin
    merged = r_DATA;
    for (int i = 0; i < 4; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      count     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      w_REQ     <= 1'b0;
      r_REQ     <= 1'b0;
      w_ADDR    <= '0;
      r_ADDR    <= '0;
      w_DATA    <= '0;
    end else begin
      w_REQ     <= 1'b0;
      r_REQ     <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid && hit && !mem_ready) begin
            addr_q  <= addr_aligned;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            if (mem_wstrb == 4'h0) begin
              r_REQ  <= 1'b1;
              r_ADDR <= addr_aligned;
              count  <= LAT_LOAD;
              state  <= RD_WAIT;
            end else if (mem_wstrb == 4'hF) begin
              w_REQ  <= 1'b1;
              w_ADDR <= addr_aligned;
              w_DATA <= mem_wdata;
              state  <= RMW_WR;
            end else begin
              r_REQ  <= 1'b1;
              r_ADDR <= addr_aligned;
              count  <= LAT_LOAD;
              state  <= RMW_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (count == 4'd0) begin
            mem_rdata <= r_DATA;
            mem_ready <= 1'b1;
            state     <= ACK;
          end else begin
            count <= count - 4'd1;
          end
        end
        RMW_WAIT: begin
          if (count == 4'd0) begin
            w_REQ  <= 1'b1;
            w_ADDR <= addr_q;
            w_DATA <= merged;
            state  <= RMW_WR;
          end else begin
            count <= count - 4'd1;
          end
        end
        RMW_WR: begin
          mem_ready <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pico_periph_bridge.sv
// Bench for pico_periph_bridge: directed vector table, hand sequences for
// reset and long latency, and random accesses against a word-memory model.
module tb_pico_periph_bridge;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        mem_valid = 1'b0, mem_valid3 = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] r_data1, r_data1_drv = '0, r_data3 = '0;
  logic        use_pmem = 1'b0;

  logic        mem_ready1, w_req1, r_req1, mem_ready3, w_req3, r_req3;
  logic [31:0] mem_rdata1, w_addr1, r_addr1, w_data1;
  logic [31:0] mem_rdata3, w_addr3, r_addr3, w_data3;

  logic [31:0] pmem [16];
  logic [31:0] ref_mem [16];

  int checks = 0;
  int failures = 0;

  always #5 iCLK = ~iCLK;

  always_comb r_data1 = use_pmem ? pmem[r_addr1[5:2]] : r_data1_drv;

  pico_periph_bridge #(.RD_LATENCY(1)) dut (
    .iCLK(iCLK), .iRST(iRST), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready1),
    .mem_rdata(mem_rdata1), .w_REQ(w_req1), .r_REQ(r_req1), .w_ADDR(w_addr1),
    .r_ADDR(r_addr1), .w_DATA(w_data1), .r_DATA(r_data1));

  pico_periph_bridge #(.RD_LATENCY(3)) dut3 (
    .iCLK(iCLK), .iRST(iRST), .mem_valid(mem_valid3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready3),
    .mem_rdata(mem_rdata3), .w_REQ(w_req3), .r_REQ(r_req3), .w_ADDR(w_addr3),
    .r_ADDR(r_addr3), .w_DATA(w_data3), .r_DATA(r_data3));

  typedef struct {
    int          rreq_cyc, rreq_cnt, wreq_cyc, wreq_cnt, rdy_cyc, rdy_cnt, both;
    logic [31:0] wdata, waddr, raddr, rdata;
  } obs_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    bit          drop;
    int          ncyc, exp_r, exp_w, exp_rdy;
    logic [31:0] exp_wdata, exp_waddr, exp_raddr, exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access on the latency-1 instance; cycle k is T0+k.
  task automatic run_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            input int ncyc, input bit drop, output obs_t o);
    o = '{-1, 0, -1, 0, -1, 0, 0, '0, '0, '0, '0};
    @(negedge iCLK);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge iCLK);
      if (r_req1) begin
        if (o.rreq_cnt == 0) o.rreq_cyc = k;
        o.rreq_cnt++; o.raddr = r_addr1;
      end
      if (w_req1) begin
        if (o.wreq_cnt == 0) o.wreq_cyc = k;
        o.wreq_cnt++; o.wdata = w_data1; o.waddr = w_addr1;
        if (use_pmem) pmem[w_addr1[5:2]] = w_data1;
      end
      if (r_req1 && w_req1) o.both++;
      if (mem_ready1) begin
        if (o.rdy_cnt == 0) begin o.rdy_cyc = k; o.rdata = mem_rdata1; end
        o.rdy_cnt++;
        mem_valid = 1'b0;
      end
      if (drop && k == 1) mem_valid = 1'b0;
    end
    mem_valid = 1'b0;
  endtask

  vec_t        vecs [6];
  obs_t        o;
  logic [31:0] exp_w, last_rd, a, wd, v;
  logic [3:0]  ws;
  int          idx, kind, rdy_seen, rq, rd_cyc;
  bit          miss;

  initial begin
    vecs[0] = '{32'h1000_0000, 32'h0000_A5A5, 4'hF, 32'h0, 1'b0, 8, -1, 1, 2,
                32'h0000_A5A5, 32'h1000_0000, 32'h0, 32'h0};
    vecs[1] = '{32'h1000_0004, 32'h0, 4'h0, 32'h0000_1234, 1'b0, 8, 1, -1, 3,
                32'h0, 32'h0, 32'h1000_0004, 32'h0000_1234};
    vecs[2] = '{32'h1000_0008, 32'hFFFF_BEEF, 4'b0011, 32'hCAFE_0000, 1'b0, 8, 1, 3, 4,
                32'hCAFE_BEEF, 32'h1000_0008, 32'h1000_0008, 32'h0000_1234};
    vecs[3] = '{32'h2000_0000, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 20, -1, -1, -1,
                32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4] = '{32'h1000_0007, 32'h1122_3344, 4'b1000, 32'h5566_7788, 1'b1, 8, 1, 3, 4,
                32'h1166_7788, 32'h1000_0004, 32'h1000_0004, 32'h0000_1234};
    vecs[5] = '{32'h1000_000E, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 8, 1, -1, 3,
                32'h0, 32'h0, 32'h1000_000C, 32'h0BAD_F00D};

    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check("reset mem_ready", {31'b0, mem_ready1}, 32'h0);
    check("reset reqs", {30'b0, w_req1, r_req1}, 32'h0);
    check("reset mem_rdata", mem_rdata1, 32'h0);
    check("reset w_DATA", w_data1, 32'h0);
    check("reset addrs", w_addr1 | r_addr1, 32'h0);
    iRST = 1'b0;

    foreach (vecs[i]) begin
      r_data1_drv = vecs[i].rdata;
      run_access(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].ncyc, vecs[i].drop, o);
      check($sformatf("v%0d r_REQ cycle", i), 32'(o.rreq_cyc), 32'(vecs[i].exp_r));
      check($sformatf("v%0d r_REQ count", i), 32'(o.rreq_cnt), (vecs[i].exp_r >= 0) ? 32'd1 : 32'd0);
      check($sformatf("v%0d w_REQ cycle", i), 32'(o.wreq_cyc), 32'(vecs[i].exp_w));
      check($sformatf("v%0d w_REQ count", i), 32'(o.wreq_cnt), (vecs[i].exp_w >= 0) ? 32'd1 : 32'd0);
      check($sformatf("v%0d ready cycle", i), 32'(o.rdy_cyc), 32'(vecs[i].exp_rdy));
      check($sformatf("v%0d ready count", i), 32'(o.rdy_cnt), (vecs[i].exp_rdy >= 0) ? 32'd1 : 32'd0);
      check($sformatf("v%0d req overlap", i), 32'(o.both), 32'd0);
      if (vecs[i].exp_w >= 0) begin
        check($sformatf("v%0d w_DATA", i), o.wdata, vecs[i].exp_wdata);
        check($sformatf("v%0d w_ADDR", i), o.waddr, vecs[i].exp_waddr);
      end
      if (vecs[i].exp_r >= 0) check($sformatf("v%0d r_ADDR", i), o.raddr, vecs[i].exp_raddr);
      if (vecs[i].exp_rdy >= 0) check($sformatf("v%0d mem_rdata", i), o.rdata, vecs[i].exp_rdata);
    end

    // Reset while a read waits on the peripheral.
    r_data1_drv = 32'h7777_0000;
    @(negedge iCLK);
    mem_valid = 1'b1; mem_addr = 32'h1000_0010; mem_wstrb = 4'h0;
    @(negedge iCLK);
    check("rst r_REQ before", {31'b0, r_req1}, 32'h1);
    iRST = 1'b1;
    @(negedge iCLK);
    mem_valid = 1'b0;
    check("rst outputs ctl", {29'b0, mem_ready1, w_req1, r_req1}, 32'h0);
    check("rst mem_rdata", mem_rdata1, 32'h0);
    check("rst w_DATA", w_data1, 32'h0);
    check("rst addrs", w_addr1 | r_addr1, 32'h0);
    rdy_seen = 0;
    repeat (4) begin
      @(negedge iCLK);
      if (mem_ready1) rdy_seen++;
    end
    iRST = 1'b0;
    repeat (3) begin
      @(negedge iCLK);
      if (mem_ready1) rdy_seen++;
    end
    check("rst no ready", 32'(rdy_seen), 32'd0);
    run_access(32'h1000_0014, 32'h0, 4'h0, 8, 1'b0, o);
    check("post-rst ready cycle", 32'(o.rdy_cyc), 32'd3);
    check("post-rst rdata", o.rdata, 32'h7777_0000);

    // Latency 3: data only valid from T0+4.
    r_data3 = 32'hDEAD_DEAD;
    @(negedge iCLK);
    mem_valid3 = 1'b1; mem_addr = 32'h1000_0020; mem_wstrb = 4'h0;
    rq = -1; rd_cyc = -1; v = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge iCLK);
      if (r_req3 && rq < 0) rq = k;
      if (mem_ready3 && rd_cyc < 0) begin rd_cyc = k; v = mem_rdata3; mem_valid3 = 1'b0; end
      if (k == 4) r_data3 = 32'h1357_9BDF;
    end
    mem_valid3 = 1'b0;
    check("lat3 r_REQ cycle", 32'(rq), 32'd1);
    check("lat3 ready cycle", 32'(rd_cyc), 32'd5);
    check("lat3 rdata", v, 32'h1357_9BDF);

    // Random accesses against a word-array model of the peripheral.
    use_pmem = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = $urandom; pmem[i] = v; ref_mem[i] = v;
    end
    last_rd = 32'h7777_0000;
    for (int n = 0; n < 40; n++) begin
      miss = ($urandom_range(0, 7) == 0);
      idx  = $urandom_range(0, 15);
      a    = miss ? 32'h3000_0000 | {26'b0, 4'(idx), 2'(n)}
                  : 32'h1000_0000 | {26'b0, 4'(idx), 2'($urandom_range(0, 3))};
      kind = $urandom_range(0, 2);
      ws   = (kind == 0) ? 4'h0 : (kind == 1) ? 4'hF : 4'($urandom_range(1, 14));
      wd   = $urandom;
      run_access(a, wd, ws, 8, 1'b0, o);
      if (miss) begin
        check($sformatf("rnd%0d miss ready", n), 32'(o.rdy_cnt), 32'd0);
        check($sformatf("rnd%0d miss reqs", n), 32'(o.rreq_cnt + o.wreq_cnt), 32'd0);
      end else begin
        exp_w = ref_mem[idx];
        for (int b = 0; b < 4; b++) if (ws[b]) exp_w[8*b +: 8] = wd[8*b +: 8];
        if (ws == 4'h0) last_rd = ref_mem[idx];
        check($sformatf("rnd%0d ready cycle", n), 32'(o.rdy_cyc),
              (ws == 4'h0) ? 32'd3 : (ws == 4'hF) ? 32'd2 : 32'd4);
        check($sformatf("rnd%0d r_REQ count", n), 32'(o.rreq_cnt), (ws == 4'hF) ? 32'd0 : 32'd1);
        check($sformatf("rnd%0d w_REQ count", n), 32'(o.wreq_cnt), (ws == 4'h0) ? 32'd0 : 32'd1);
        check($sformatf("rnd%0d mem_rdata", n), o.rdata, last_rd);
        if (ws != 4'h0) begin
          check($sformatf("rnd%0d w_DATA", n), o.wdata, exp_w);
          check($sformatf("rnd%0d w_ADDR", n), o.waddr, {a[31:2], 2'b00});
          ref_mem[idx] = exp_w;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
